// File: rtl/tlb_refill_walker.sv
// Hardware page-table walker that refills the TLB on a miss: one outstanding
// page-table read, a TLB write-random strobe on success, and a sticky page fault otherwise.
module tlb_refill_walker #(
  parameter int PTE_V_BIT = 0
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic [19:0] vpn,
  input  logic        tlb_hit,
  input  logic [31:0] ptbase,
  input  logic        flush,
  input  logic        sw_tlbw,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [23:0] pte_out,
  output logic        tlbwr,
  output logic        stall,
  output logic        page_fault,
  output logic [19:0] bad_vpn,
  output logic [15:0] refill_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALK   = 3'd1,
    FILL   = 3'd2,
    SETTLE = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t      state;
  logic [19:0] walk_vpn;
  logic        drop;
  logic        miss;
  logic        unused_rdata_hi;

  // Only the low 24 bits of a page-table word carry the PTE.
  assign unused_rdata_hi = ^mem_rdata[31:24];

  assign miss  = req & ~tlb_hit;
  assign stall = ((state == IDLE) & miss) | ((state != IDLE) & (state != FAULT));

  // The write strobe must yield to a software TLB write in the same cycle,
  // so it is decoded from the current inputs rather than registered.
  assign tlbwr = (state == FILL) & ~sw_tlbw & ~flush;

  // NOTE: all state uses non-blocking assignments and an asynchronous reset,
  // so every register updates together on the edge and clears without a clock.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      walk_vpn   <= '0;
      drop       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      pte_out    <= '0;
      page_fault <= 1'b0;
      bad_vpn    <= '0;
      refill_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss && !flush) begin
            walk_vpn <= vpn;
            mem_req  <= 1'b1;
            // Address is frozen at walk start so it stays steady until the ack.
            mem_addr <= ptbase + {10'd0, vpn, 2'b00};
            state    <= WALK;
          end
        end

        WALK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            drop    <= 1'b0;
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              pte_out <= mem_rdata[23:0];
              if (mem_rdata[PTE_V_BIT]) begin
                state <= FILL;
              end else begin
                page_fault <= 1'b1;
                bad_vpn    <= walk_vpn;
                state      <= FAULT;
              end
            end
          end else if (flush) begin
            // The read is already in flight; remember to discard its data.
            drop <= 1'b1;
          end
        end

        FILL: begin
          if (flush) begin
            state <= IDLE;
          end else if (!sw_tlbw) begin
            if (refill_cnt != 16'hFFFF) refill_cnt <= refill_cnt + 16'd1;
            state <= SETTLE;
          end
        end

        SETTLE: begin
          state <= IDLE;
        end

        FAULT: begin
          if (flush) begin
            page_fault <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tlb_refill_walker.md
TLB_REFILL_WALKER -- requirements
Module: tlb_refill_walker

Interface
REQ-001 SHALL have parameter PTE_V_BIT, default 0, giving the bit index of the PTE valid flag within the 24-bit PTE.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clrn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 1, a translation request is valid this cycle.
REQ-005 SHALL have port vpn, input, 20, the virtual page number of the request.
REQ-006 SHALL have port tlb_hit, input, 1, the TLB hit for vpn in the same cycle.
REQ-007 SHALL have port ptbase, input, 32, the page-table base byte address.
REQ-008 SHALL have port flush, input, 1, abort any walk in progress.
REQ-009 SHALL have port sw_tlbw, input, 1, a software TLB write (tlbwi/tlbwr from CP0) this cycle.
REQ-010 SHALL have port mem_req, output, 1, a page-table read request.
REQ-011 SHALL have port mem_addr, output, 32, the page-table read address.
REQ-012 SHALL have port mem_ack, input, 1, read data is valid this cycle.
REQ-013 SHALL have port mem_rdata, input, 32, read data; bits [23:0] are the PTE.
REQ-014 SHALL have port pte_out, output, 24, the PTE to the TLB pte_in.
REQ-015 SHALL have port tlbwr, output, 1, a TLB write-random strobe.
REQ-016 SHALL have port stall, output, 1, the requester must hold the request.
REQ-017 SHALL have port page_fault, output, 1, the fetched PTE is invalid.
REQ-018 SHALL have port bad_vpn, output, 20, the VPN that faulted.
REQ-019 SHALL have port refill_cnt, output, 16, the count of completed refills.

Function
REQ-020 SHALL use the FSM states IDLE, WALK, FILL, SETTLE and FAULT.
REQ-021 In IDLE, req & ~tlb_hit & ~flush SHALL latch vpn into a walk register and move to WALK on the next edge.
REQ-022 In IDLE, req & tlb_hit SHALL stay in IDLE with no side effects.
REQ-023 stall SHALL equal (state==IDLE & req & ~tlb_hit) | (state!=IDLE & state!=FAULT); it is combinational.
REQ-024 In WALK, mem_req SHALL be 1 and mem_addr SHALL be ptbase + {walk_vpn,2'b00}, modulo 2^32 (wrap, no carry-out).
REQ-025 mem_req and mem_addr SHALL hold steady until mem_ack; mem_req SHALL be 0 in every other state.
REQ-026 In WALK, on mem_ack, mem_rdata[23:0] SHALL be captured into the PTE register.
  - PTE[PTE_V_BIT]=1 -> next state FILL.
  - PTE[PTE_V_BIT]=0 -> next state FAULT.
REQ-027 In FILL, tlbwr SHALL be 1 only if sw_tlbw=0; if sw_tlbw=1 the block SHALL stay in FILL with tlbwr=0 (software write wins).
REQ-028 A FILL cycle with tlbwr=1 SHALL increment refill_cnt, saturating at 16'hFFFF, and go to SETTLE.
REQ-029 pte_out SHALL always drive the PTE register.
REQ-030 SETTLE SHALL last exactly one cycle and then go to IDLE, so that the requester re-looks-up and hits.
REQ-031 Miss-to-tlbwr latency SHALL be 2 cycles + memory latency; with mem_ack in the first WALK cycle, tlbwr is asserted in the cycle after mem_ack.
REQ-032 On entering FAULT, page_fault SHALL be 1 and bad_vpn SHALL be walk_vpn.
  - Both hold until flush, then the block returns to IDLE.
  - page_fault=1 does not stall; the requester takes the exception.
REQ-033 flush in IDLE, SETTLE or FAULT SHALL force IDLE on the next edge.
REQ-034 flush in FILL SHALL force IDLE with tlbwr=0 that cycle.
REQ-035 flush in WALK SHALL set a drop flag; mem_req stays asserted until mem_ack, then the block goes to IDLE without FILL or FAULT, and the drop flag clears.
REQ-036 flush and mem_ack in the same WALK cycle SHALL behave as a drop.
REQ-037 A new miss SHALL NOT be accepted while state!=IDLE; one walk is outstanding at a time.

Reset
REQ-038 clrn=0 SHALL immediately force state=IDLE, mem_req=0, tlbwr=0, page_fault=0, pte_out=0, bad_vpn=0, refill_cnt=0, and the drop flag cleared, regardless of a walk in progress.
REQ-039 mem_ack arriving after a reset SHALL be ignored in IDLE.

Verification
REQ-040 Basic miss:
  - Stimulus: ptbase=32'h0001_0000, vpn=20'h00ABC, req=1, tlb_hit=0; mem_ack 3 cycles later with rdata=32'h0012_3451.
  - Response: mem_addr=32'h0001_2AF0; tlbwr pulses one cycle with pte_out=24'h123451; refill_cnt=1; stall drops after SETTLE.
REQ-041 Invalid PTE:
  - Stimulus: rdata=32'h0000_0000.
  - Response: no tlbwr; page_fault=1 and bad_vpn=vpn until flush; then IDLE.
REQ-042 Flush mid-walk:
  - Stimulus: flush one cycle in WALK; mem_ack 2 cycles later.
  - Response: mem_req holds until ack; no tlbwr; IDLE after ack.
REQ-043 Software write conflict:
  - Stimulus: sw_tlbw=1 for 2 cycles while in FILL.
  - Response: tlbwr is delayed exactly 2 cycles, then pulses once.
REQ-044 Address wrap and saturation:
  - Stimulus: ptbase=32'hFFFF_FFF8, vpn=20'h00003.
  - Response: mem_addr=32'h0000_0004.
  - Stimulus: preload refill_cnt to 16'hFFFF, then complete a refill.
  - Response: refill_cnt stays 16'hFFFF.
REQ-045 Reset mid-walk:
  - Stimulus: clrn=0 asynchronously during WALK.
  - Response: mem_req=0 immediately, all outputs at reset values.
